// File: rtl/reg_pkg.sv
// Shared definitions for the universal shift register and the controllers
// that drive its mode input.
package reg_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_ASR  = 3'b110;
    localparam mode_t MODE_RSVD = 3'b111;  // treated as hold

endpackage

// File: rtl/usr_next_state.sv
// Combinational next-value function of the universal shift register.
// The single-bit width is handled separately so no out-of-range bit is ever
// referenced: there, shifts take the serial input and rotates/ASR hold.
module usr_next_state
    import reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    input  mode_t        mode,
    input  logic         sin_l,
    input  logic         sin_r,
    output logic [N-1:0] q_next
);

    generate
        if (N == 1) begin : g_one
            // One-bit register: only load and the two serial shifts change q
            always_comb begin
                q_next = q;
                case (mode)
                    MODE_LOAD: q_next = d;
                    MODE_SHL:  q_next = sin_r;
                    MODE_SHR:  q_next = sin_l;
                    default:   q_next = q;
                endcase
            end
        end else begin : g_wide
            logic [N-1:0] shl;
            logic [N-1:0] shr;
            logic [N-1:0] rol;
            logic [N-1:0] ror;
            logic [N-1:0] asr;

            // Build every shifted candidate bit by bit; the end bits pick up
            // the serial input, the wrapped bit or the sign bit.
            for (genvar gi = 0; gi < N; gi++) begin : g_bit
                if (gi == 0) begin : g_lsb_up
                    assign shl[gi] = sin_r;
                    assign rol[gi] = q[N-1];
                end else begin : g_mid_up
                    assign shl[gi] = q[gi-1];
                    assign rol[gi] = q[gi-1];
                end

                if (gi == N - 1) begin : g_msb_down
                    assign shr[gi] = sin_l;
                    assign ror[gi] = q[0];
                    assign asr[gi] = q[N-1];
                end else begin : g_mid_down
                    assign shr[gi] = q[gi+1];
                    assign ror[gi] = q[gi+1];
                    assign asr[gi] = q[gi+1];
                end
            end

            // Select the candidate for the requested mode
            always_comb begin
                q_next = q;
                case (mode)
                    MODE_LOAD: q_next = d;
                    MODE_SHL:  q_next = shl;
                    MODE_SHR:  q_next = shr;
                    MODE_ROL:  q_next = rol;
                    MODE_ROR:  q_next = ror;
                    MODE_ASR:  q_next = asr;
                    default:   q_next = q;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/univ_shift_register.sv
// N-bit universal register: hold, load, logical shift, rotate and arithmetic
// shift right, with serial taps at both ends. Priority at each edge is
// clr > en low (hold) > sclr > mode.
module univ_shift_register
    import reg_pkg::*;
#(
    parameter int            N         = 8,
    parameter logic [N-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         sclr,
    input  logic [2:0]   mode,
    input  logic [N-1:0] d,
    input  logic         sin_r,
    input  logic         sin_l,
    output logic [N-1:0] q,
    output logic         sout_l,
    output logic         sout_r
);

    logic [N-1:0] q_next;

    usr_next_state #(
        .N(N)
    ) u_next (
        .q      (q),
        .d      (d),
        .mode   (mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (q_next)
    );

    // State register: async clear, then enable gate, then sync clear
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            if (sclr) begin
                q <= RESET_VAL;
            end else begin
                q <= q_next;
            end
        end
    end

    // Serial outputs are the end bits of the stored value
    assign sout_l = q[N-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: three builds (N = 4 with RESET_VAL 1010,
// N = 1, N = 16), vector tables plus hand-written reset/abort sequences,
// expected values queued at drive time and compared after the edge.
module tb_univ_shift_register;
    import reg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N = 4 build
    logic       clr4 = 1'b0, en4 = 1'b0, sclr4 = 1'b0, sinr4 = 1'b0, sinl4 = 1'b0;
    logic [2:0] mode4 = 3'b000;
    logic [3:0] d4 = '0, q4;
    logic       soutl4, soutr4;

    // N = 1 build
    logic       clr1 = 1'b1, en1 = 1'b0, sclr1 = 1'b0, sinr1 = 1'b0, sinl1 = 1'b0;
    logic [2:0] mode1 = 3'b000;
    logic [0:0] d1 = '0, q1;
    logic       soutl1, soutr1;

    // N = 16 build
    logic        clr16 = 1'b1, en16 = 1'b0, sclr16 = 1'b0, sinr16 = 1'b0, sinl16 = 1'b0;
    logic [2:0]  mode16 = 3'b000;
    logic [15:0] d16 = '0, q16;
    logic        soutl16, soutr16;

    univ_shift_register #(.N(4), .RESET_VAL(4'b1010)) dut4 (
        .clk(clk), .clr(clr4), .en(en4), .sclr(sclr4), .mode(mode4), .d(d4),
        .sin_r(sinr4), .sin_l(sinl4), .q(q4), .sout_l(soutl4), .sout_r(soutr4)
    );

    univ_shift_register #(.N(1)) dut1 (
        .clk(clk), .clr(clr1), .en(en1), .sclr(sclr1), .mode(mode1), .d(d1),
        .sin_r(sinr1), .sin_l(sinl1), .q(q1), .sout_l(soutl1), .sout_r(soutr1)
    );

    univ_shift_register #(.N(16)) dut16 (
        .clk(clk), .clr(clr16), .en(en16), .sclr(sclr16), .mode(mode16), .d(d16),
        .sin_r(sinr16), .sin_l(sinl16), .q(q16), .sout_l(soutl16), .sout_r(soutr16)
    );

    // mode must never be unknown while enabled
    always @(posedge clk) begin
        if (en4 === 1'b1) assert (!$isunknown(mode4)) else $error("mode4 unknown while en4=1");
        if (en1 === 1'b1) assert (!$isunknown(mode1)) else $error("mode1 unknown while en1=1");
        if (en16 === 1'b1) assert (!$isunknown(mode16)) else $error("mode16 unknown while en16=1");
    end

    typedef struct {
        int          which;
        logic        en;
        logic        sclr;
        logic [2:0]  mode;
        logic [15:0] d;
        logic        sinr;
        logic        sinl;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          which;
        logic [15:0] exp;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model4 = 'x, model1 = 'x, model16 = 'x;

    function automatic vec_t mk(int w, logic e, logic s, logic [2:0] m, logic [15:0] dd,
                                logic sr, logic sl, logic [15:0] x);
        vec_t v;
        v.which = w; v.en = e; v.sclr = s; v.mode = m; v.d = dd;
        v.sinr = sr; v.sinl = sl; v.exp = x;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Apply one vector: check serial taps against the model before the edge,
    // queue the expected q, clock once, then pop and compare.
    task automatic run_vec(input vec_t v, input string nm);
        sb_t e;
        logic [15:0] act;
        case (v.which)
            4: begin
                en4 = v.en; sclr4 = v.sclr; mode4 = v.mode; d4 = v.d[3:0];
                sinr4 = v.sinr; sinl4 = v.sinl;
                if (!$isunknown(model4)) begin
                    check({nm, ".sout_l"}, {15'd0, soutl4}, {15'd0, model4[3]});
                    check({nm, ".sout_r"}, {15'd0, soutr4}, {15'd0, model4[0]});
                end
            end
            1: begin
                en1 = v.en; sclr1 = v.sclr; mode1 = v.mode; d1 = v.d[0:0];
                sinr1 = v.sinr; sinl1 = v.sinl;
            end
            default: begin
                en16 = v.en; sclr16 = v.sclr; mode16 = v.mode; d16 = v.d;
                sinr16 = v.sinr; sinl16 = v.sinl;
                if (!$isunknown(model16)) begin
                    check({nm, ".sout_l"}, {15'd0, soutl16}, {15'd0, model16[15]});
                end
            end
        endcase
        e.which = v.which;
        e.exp = v.exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (e.which)
            4:       begin act = {12'd0, q4};  model4  = e.exp; end
            1:       begin act = {15'd0, q1};  model1  = e.exp; end
            default: begin act = q16;          model16 = e.exp; end
        endcase
        check({nm, ".q"}, act, e.exp);
    endtask

    initial begin
        // Bring N=1 and N=16 out of reset; N=4 is loaded first, then cleared mid-cycle
        #1;
        check("n1.reset_q", {15'd0, q1}, 16'h0000);
        check("n16.reset_q", q16, 16'h0000);
        @(posedge clk); #1;
        clr1 = 1'b0; clr16 = 1'b0;
        model1 = 16'h0000; model16 = 16'h0000;

        run_vec(mk(4, 1, 0, MODE_LOAD, 16'h0, 0, 0, 16'h0), "n4.preload");

        // Async clear in the middle of a cycle must act before any edge
        #3 clr4 = 1'b1;
        #1;
        check("n4.clr_async_q", {12'd0, q4}, 16'h000A);
        check("n4.clr_sout_l", {15'd0, soutl4}, 16'h0001);
        check("n4.clr_sout_r", {15'd0, soutr4}, 16'h0000);
        #1 clr4 = 1'b0;
        model4 = 16'h000A;

        // N = 4 table
        tbl.push_back(mk(4, 1, 0, MODE_HOLD, 16'h0, 1, 1, 16'hA));
        tbl.push_back(mk(4, 1, 0, MODE_HOLD, 16'h0, 1, 1, 16'hA));
        tbl.push_back(mk(4, 1, 0, MODE_HOLD, 16'h0, 1, 1, 16'hA));
        tbl.push_back(mk(4, 1, 0, MODE_LOAD, 16'h9, 0, 0, 16'h9));
        tbl.push_back(mk(4, 1, 0, MODE_SHL,  16'h0, 1, 0, 16'h3));
        tbl.push_back(mk(4, 1, 0, MODE_SHL,  16'h0, 1, 0, 16'h7));
        tbl.push_back(mk(4, 1, 0, MODE_LOAD, 16'h9, 0, 0, 16'h9));
        tbl.push_back(mk(4, 1, 0, MODE_ROR,  16'h0, 0, 0, 16'hC));
        tbl.push_back(mk(4, 1, 0, MODE_ROL,  16'h0, 0, 0, 16'h9));
        tbl.push_back(mk(4, 1, 0, MODE_LOAD, 16'h8, 0, 0, 16'h8));
        tbl.push_back(mk(4, 1, 0, MODE_ASR,  16'h0, 0, 0, 16'hC));
        tbl.push_back(mk(4, 1, 0, MODE_ASR,  16'h0, 0, 0, 16'hE));
        tbl.push_back(mk(4, 1, 0, MODE_ASR,  16'h0, 0, 0, 16'hF));
        tbl.push_back(mk(4, 1, 0, MODE_LOAD, 16'h6, 0, 0, 16'h6));
        tbl.push_back(mk(4, 0, 1, MODE_LOAD, 16'hF, 0, 0, 16'h6));
        tbl.push_back(mk(4, 1, 1, MODE_LOAD, 16'hF, 0, 0, 16'hA));
        tbl.push_back(mk(4, 1, 0, MODE_RSVD, 16'h5, 1, 1, 16'hA));
        tbl.push_back(mk(4, 1, 0, MODE_LOAD, 16'h0, 0, 0, 16'h0));
        tbl.push_back(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 1, 16'h8));
        tbl.push_back(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 0, 16'h4));
        tbl.push_back(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 1, 16'hA));
        tbl.push_back(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 1, 16'hD));
        tbl.push_back(mk(4, 0, 0, MODE_SHL,  16'h0, 1, 1, 16'hD));
        // N = 1 table
        tbl.push_back(mk(1, 1, 0, MODE_LOAD, 16'h1, 0, 0, 16'h1));
        tbl.push_back(mk(1, 1, 0, MODE_ROL,  16'h0, 0, 0, 16'h1));
        tbl.push_back(mk(1, 1, 0, MODE_ROR,  16'h0, 0, 0, 16'h1));
        tbl.push_back(mk(1, 1, 0, MODE_ASR,  16'h0, 0, 0, 16'h1));
        tbl.push_back(mk(1, 1, 0, MODE_SHL,  16'h1, 0, 1, 16'h0));
        tbl.push_back(mk(1, 1, 0, MODE_RSVD, 16'h1, 1, 1, 16'h0));
        tbl.push_back(mk(1, 1, 0, MODE_SHR,  16'h0, 0, 1, 16'h1));
        tbl.push_back(mk(1, 1, 1, MODE_LOAD, 16'h1, 1, 1, 16'h0));
        // N = 16 table
        tbl.push_back(mk(16, 1, 0, MODE_LOAD, 16'h8001, 0, 0, 16'h8001));
        tbl.push_back(mk(16, 1, 0, MODE_ASR,  16'h0,    0, 0, 16'hC000));
        tbl.push_back(mk(16, 1, 0, MODE_ASR,  16'h0,    0, 0, 16'hE000));
        tbl.push_back(mk(16, 1, 0, MODE_SHL,  16'h0,    1, 0, 16'hC001));
        tbl.push_back(mk(16, 1, 0, MODE_ROR,  16'h0,    0, 0, 16'hE000));
        tbl.push_back(mk(16, 1, 0, MODE_ROL,  16'h0,    0, 0, 16'hC001));
        tbl.push_back(mk(16, 1, 0, MODE_SHR,  16'h0,    0, 0, 16'h6000));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Serial-in sequence aborted by an async clear after the 2nd edge
        run_vec(mk(4, 1, 0, MODE_LOAD, 16'h0, 0, 0, 16'h0), "abort.load");
        run_vec(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 1, 16'h8), "abort.shr1");
        run_vec(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 0, 16'h4), "abort.shr2");
        #2 clr4 = 1'b1;
        #1;
        check("abort.clr_q", {12'd0, q4}, 16'h000A);
        #1 clr4 = 1'b0;
        model4 = 16'h000A;
        run_vec(mk(4, 1, 0, MODE_HOLD, 16'h0, 0, 1, 16'hA), "abort.hold");
        run_vec(mk(4, 1, 0, MODE_SHR,  16'h0, 0, 1, 16'hD), "abort.shr3");

        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
